// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
//   Bundle of the two requester ports, the muxed memory bus toward the
//   address decoder, and the per-port read return paths.
//   Modports:
//     slave  - arbiter view: requests/addr/wr/wdata and bus_rdata in,
//              grants, read returns, muxed bus and busy out.
//     master - environment view (requesters plus decoder read mux).
//   Parameters: AW address width, DW data width.
interface mem_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // requester side
  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic          wr0;
  logic          wr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          rvalid0;
  logic          rvalid1;
  // decoder / memory side
  logic [AW-1:0] bus_addr;
  logic          bus_WR;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          busy;

  modport slave (
    input  req0, req1, addr0, addr1, wr0, wr1, wdata0, wdata1, bus_rdata,
    output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
    output bus_addr, bus_WR, bus_wdata, busy
  );

  modport master (
    output req0, req1, addr0, addr1, wr0, wr1, wdata0, wdata1, bus_rdata,
    input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
    input  bus_addr, bus_WR, bus_wdata, busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Round-robin arbiter sharing one memory-mapped bus between the processor
//   (port 0) and the image-stream engine (port 1). Drives the muxed
//   address / WR / write-data bus and routes the one-cycle-late read data
//   back to whichever port issued the read.
//   Ports:
//     clk  - system clock
//     rst  - synchronous active-high reset
//     bus  - mem_bus_arbiter_if.slave (requests, grants, read returns,
//            muxed bus, busy)
//   Parameters: AW, DW widths; MAX_HOLD consecutive transfers allowed per
//   grant while the other port waits.
//   Optional feature: define ARB_HOLD_LIMIT_EN to preempt an owner after
//   MAX_HOLD transfers when the other port is requesting. Without it a
//   grant lasts until the owner releases and MAX_HOLD is unused.
module mem_bus_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.slave  bus
);

  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("mem_bus_arbiter: MAX_HOLD must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;     // port that most recently released
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          busy_q, busy_d;
  logic [1:0]    rd_pend_q, rd_pend_d; // read issued last cycle, per port
  logic          xfer0, xfer1;
  logic          hold_hit;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdata_mux;
  logic          wr_mux;

  assign xfer0 = gnt0_q && bus.req0;
  assign xfer1 = gnt1_q && bus.req1;

`ifdef ARB_HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_q, hold_d, hold_inc;

  // hold_inc counts transfers of the current grant including this cycle's
  // beat, so the owner is cut off right after its MAX_HOLD-th transfer.
  always_comb begin
    hold_inc = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
    hold_hit = (hold_inc == HW'(MAX_HOLD));
  end
`else
  assign hold_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 && bus.req1) state_d = last_q ? OWN0 : OWN1;
        else if (bus.req0)        state_d = OWN0;
        else if (bus.req1)        state_d = OWN1;
      end
      OWN0: begin
        if (!bus.req0 || (hold_hit && bus.req1)) begin
          last_d  = 1'b0;
          state_d = bus.req1 ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!bus.req1 || (hold_hit && bus.req0)) begin
          last_d  = 1'b1;
          state_d = bus.req0 ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    gnt0_d    = (state_d == OWN0);
    gnt1_d    = (state_d == OWN1);
    busy_d    = (state_d != IDLE);
    rd_pend_d = {xfer1 && !bus.wr1, xfer0 && !bus.wr0};

`ifdef ARB_HOLD_LIMIT_EN
    if (state_d != state_q)  hold_d = '0;
    else if (state_q != IDLE) hold_d = hold_inc;
    else                     hold_d = hold_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      busy_q    <= 1'b0;
      rd_pend_q <= 2'b00;
`ifdef ARB_HOLD_LIMIT_EN
      hold_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      busy_q    <= busy_d;
      rd_pend_q <= rd_pend_d;
`ifdef ARB_HOLD_LIMIT_EN
      hold_q    <= hold_d;
`endif
    end
  end

  // Bus mux follows the owner; WR is gated by the live request so a
  // dropped request never writes.
  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    wr_mux    = 1'b0;
    case (state_q)
      OWN0: begin
        addr_mux  = bus.addr0;
        wdata_mux = bus.wdata0;
        wr_mux    = bus.wr0 && bus.req0;
      end
      OWN1: begin
        addr_mux  = bus.addr1;
        wdata_mux = bus.wdata1;
        wr_mux    = bus.wr1 && bus.req1;
      end
      default: ;
    endcase
  end

  assign bus.bus_addr  = addr_mux;
  assign bus.bus_wdata = wdata_mux;
  assign bus.bus_WR    = wr_mux;
  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.busy      = busy_q;

  // Read data is steered by the recorded issuer, not the current owner.
  assign bus.rvalid0 = rd_pend_q[0];
  assign bus.rvalid1 = rd_pend_q[1];
  assign bus.rdata0  = rd_pend_q[0] ? bus.bus_rdata : '0;
  assign bus.rdata1  = rd_pend_q[1] ? bus.bus_rdata : '0;

endmodule
